// File: rtl/logic_arb_pkg.sv
// logic_arb_pkg: opcode encodings and result-slot state type for logic_arb.
package logic_arb_pkg;
`include "logic_ops.vh"

   // Result slot occupancy; FULL is exactly resp_valid=1.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } arb_state_e;
endpackage

// File: rtl/logic_ops.vh
// Opcode encodings shared by the logic_arb block and its bench.
// Included from logic_arb_pkg; consumers import the package.
`ifndef LOGIC_OPS_VH
`define LOGIC_OPS_VH
localparam logic [1:0] LOP_AND = 2'b00;
localparam logic [1:0] LOP_OR  = 2'b01;
localparam logic [1:0] LOP_XOR = 2'b10;
localparam logic [1:0] LOP_NOR = 2'b11;
`endif

// File: rtl/logic_unit.sv
// logic_unit: combinational bitwise operation on two WIDTH-bit operands.
//   op : 2-bit opcode (AND, OR, XOR, NOR)
//   a,b: operands
//   f  : result
module logic_unit
   import logic_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] f
);

   always_comb begin
      f = '0;
      case (op)
         LOP_AND: f = a & b;
         LOP_OR:  f = a | b;
         LOP_XOR: f = a ^ b;
         LOP_NOR: f = ~(a | b);
         default: f = '0;
      endcase
   end

endmodule

// File: rtl/logic_arb.sv
// logic_arb: two requesters share one logic_unit and one registered result
// slot. Round-robin arbitration via a one-bit priority pointer.
//   clk, reset             : clock, synchronous active-high reset
//   reqN_valid/ready       : requester N handshake (ready is combinational)
//   reqN_op, reqN_a/b      : requester N opcode and operands
//   resp_valid/ready       : result slot handshake
//   resp_id, resp_f        : owner index and registered result
module logic_arb
   import logic_arb_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned RST_PTR = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_f
);

   localparam logic RST_PTR_BIT = RST_PTR[0];

   arb_state_e       state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             resp_id_q, resp_id_d;
   logic [WIDTH-1:0] resp_f_q, resp_f_d;

   logic             slot_free;
   logic             gnt_any;
   logic             gnt_idx;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [WIDTH-1:0] unit_f;

   // Arbitration. Reset masks the grant so no requester sees ready while
   // the slot is being cleared.
   always_comb begin
      slot_free = (state_q == ST_EMPTY) || resp_ready;
      gnt_any   = 1'b0;
      gnt_idx   = ptr_q;
      if (!reset && slot_free) begin
         if (req0_valid && req1_valid) begin
            gnt_any = 1'b1;
            gnt_idx = ptr_q;
         end else if (req0_valid) begin
            gnt_any = 1'b1;
            gnt_idx = 1'b0;
         end else if (req1_valid) begin
            gnt_any = 1'b1;
            gnt_idx = 1'b1;
         end
      end
      req0_ready = gnt_any && !gnt_idx;
      req1_ready = gnt_any &&  gnt_idx;
   end

   always_comb begin
      sel_op = gnt_idx ? req1_op : req0_op;
      sel_a  = gnt_idx ? req1_a  : req0_a;
      sel_b  = gnt_idx ? req1_b  : req0_b;
   end

   logic_unit #(.WIDTH(WIDTH)) u_unit (
      .op (sel_op),
      .a  (sel_a),
      .b  (sel_b),
      .f  (unit_f)
   );

   // Next-state: a grant loads the slot in either state (same-cycle drain
   // and refill when FULL); FULL drains only on resp_ready without a grant.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      resp_id_d = resp_id_q;
      resp_f_d  = resp_f_q;
      case (state_q)
         ST_EMPTY: begin
            if (gnt_any) state_d = ST_FULL;
         end
         ST_FULL: begin
            if (!gnt_any && resp_ready) state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
      if (gnt_any) begin
         ptr_d     = ~gnt_idx;
         resp_id_d = gnt_idx;
         resp_f_d  = unit_f;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_EMPTY;
         ptr_q     <= RST_PTR_BIT;
         resp_id_q <= 1'b0;
         resp_f_q  <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         resp_id_q <= resp_id_d;
         resp_f_q  <= resp_f_d;
      end
   end

   assign resp_valid = (state_q == ST_FULL);
   assign resp_id    = resp_id_q;
   assign resp_f     = resp_f_q;

endmodule

// File: tb/tb_logic_arb.sv
// tb_logic_arb: directed and randomized checking of logic_arb against a
// transaction-level reference model of the arbiter and result slot.
module tb_logic_arb;
   import logic_arb_pkg::*;

   localparam int unsigned W   = 32;
   localparam int unsigned RPT = 0;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]    req0_op, req1_op;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic          resp_valid, resp_ready, resp_id;
   logic [W-1:0]  resp_f;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model of the slot contents and priority pointer.
   logic          m_known = 1'b0;
   logic          m_valid, m_id, m_ptr;
   logic [W-1:0]  m_f;

   always #5 clk = ~clk;

   logic_arb #(.WIDTH(W), .RST_PTR(RPT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_f     (resp_f)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         LOP_AND: return a & b;
         LOP_OR:  return a | b;
         LOP_XOR: return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // One clock cycle: check registered outputs, drive inputs, check readies
   // against the model's grant, then advance the model at the rising edge.
   task automatic cyc(input logic rst,
                      input logic v0, input logic [1:0] o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic v1, input logic [1:0] o1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input logic rr);
      int g;
      @(negedge clk);
      if (m_known) begin
         check("resp_valid", resp_valid, m_valid);
         check("resp_id", resp_id, m_id);
         check("resp_f", resp_f, m_f);
      end
      reset = rst; resp_ready = rr;
      req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
      #1;
      g = -1;
      if (!rst && m_known && (!m_valid || rr)) begin
         if (v0 && v1) g = m_ptr ? 1 : 0;
         else if (v0)  g = 0;
         else if (v1)  g = 1;
      end
      if (m_known || rst) begin
         check("req0_ready", req0_ready, g == 0);
         check("req1_ready", req1_ready, g == 1);
      end
      @(posedge clk);
      if (rst) begin
         m_known = 1'b1; m_valid = 1'b0; m_id = 1'b0; m_f = '0; m_ptr = RPT[0];
      end else if (g >= 0) begin
         m_valid = 1'b1;
         m_id    = (g == 1);
         m_f     = (g == 1) ? ref_op(o1, a1, b1) : ref_op(o0, a0, b0);
         m_ptr   = (g == 0);
      end else if (rr) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic idle(input logic rr);
      cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, '0, rr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] held_f;
      logic [W-1:0] op_exp [4];
      op_exp[0] = 32'h0A0A0505; op_exp[1] = 32'hAFAF5F5F;
      op_exp[2] = 32'hA5A55A5A; op_exp[3] = 32'h5050A0A0;

      // Reset with both requesters valid: readies must stay low.
      cyc(1'b1, 1'b1, LOP_OR, '1, '0, 1'b1, LOP_OR, '1, '0, 1'b0);
      cyc(1'b1, 1'b1, LOP_OR, '1, '0, 1'b1, LOP_OR, '1, '0, 1'b1);

      // Single AND from requester 0.
      cyc(1'b0, 1'b1, LOP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, LOP_OR, '0, '0, 1'b1);
      #1;
      check("and_valid", resp_valid, 1'b1);
      check("and_id", resp_id, 1'b0);
      check("and_f", resp_f, 32'hF000F000);

      // Idle drain: valid 1 then 0, pointer untouched (next contention goes to 1).
      idle(1'b1);
      #1;
      check("drain_valid", resp_valid, 1'b0);
      idle(1'b1);
      cyc(1'b0, 1'b1, LOP_XOR, 32'h1, 32'h2, 1'b1, LOP_XOR, 32'h4, 32'h8, 1'b1);
      #1;
      check("drain_ptr_id", resp_id, 1'b1);

      // Contention after reset: ids 0,1,0,1,...
      cyc(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, '0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b1, LOP_OR, 32'h11 * i, 32'h100, 1'b1, LOP_AND, 32'hFFFF, 32'h22 * i, 1'b1);
         #1;
         check("alt_id", resp_id, (i % 2) == 1);
      end

      // Backpressure: three stalled cycles, then same-cycle drain and refill.
      held_f = m_f;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, LOP_NOR, $urandom, $urandom, 1'b1, LOP_XOR, $urandom, $urandom, 1'b0);
         #1;
         check("bp_hold_f", resp_f, held_f);
      end
      cyc(1'b0, 1'b1, LOP_NOR, 32'h0, 32'h0, 1'b1, LOP_NOR, 32'h0, 32'hFFFF0000, 1'b1);
      idle(1'b1);

      // All four ops on fixed operands.
      for (int op = 0; op < 4; op++) begin
         cyc(1'b0, 1'b1, 2'(op), 32'hAAAA5555, 32'h0F0F0F0F, 1'b0, 2'b00, '0, '0, 1'b1);
         #1;
         check("op_table", resp_f, op_exp[op]);
      end

      // Reset while a result is held under backpressure.
      cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, LOP_OR, 32'h5A, 32'hA500, 1'b0);
      idle(1'b0);
      cyc(1'b1, 1'b1, LOP_OR, '1, '1, 1'b1, LOP_OR, '1, '1, 1'b0);
      #1;
      check("rst_valid", resp_valid, 1'b0);
      check("rst_f", resp_f, '0);
      cyc(1'b0, 1'b1, LOP_AND, '1, '1, 1'b1, LOP_AND, '1, '1, 1'b1);
      #1;
      check("rst_ptr_id", resp_id, RPT[0]);

      // Randomized traffic with occasional reset and backpressure.
      for (int i = 0; i < 500; i++) begin
         cyc(($urandom_range(0, 59) == 0),
             1'($urandom), 2'($urandom), $urandom, $urandom,
             1'($urandom), 2'($urandom), $urandom, $urandom,
             ($urandom_range(0, 3) != 0));
      end
      idle(1'b1);
      idle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
